// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined-mode initiator: one command in, one
// single-beat WB transaction out, one response back, with an optional ack timeout.
module wb_cmd_master #(
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [AW-1:0]     i_cmd_addr,
  input  logic [DW-1:0]     i_cmd_data,
  input  logic [DW/8-1:0]   i_cmd_sel,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DW-1:0]     o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DW-1:0]     i_wb_data,
  input  logic              i_wb_err
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            timeout_hit;

  // Counter equals the number of cycles elapsed since the first stb cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_cmd_valid) state_d = REQ;
      REQ: begin
        if (timeout_hit)      state_d = RESP;
        else if (!i_wb_stall) state_d = WAIT;
      end
      WAIT: if (i_wb_err || i_wb_ack || timeout_hit) state_d = RESP;
      RESP: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          we_d   = i_cmd_we;
          addr_d = i_cmd_addr;
          data_d = i_cmd_data;
          sel_d  = i_cmd_sel;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          cnt_d  = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (!i_wb_stall) begin
          stb_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // Error outranks a simultaneous ack; an ack on the timeout cycle still completes.
        if (i_wb_err || timeout_hit && !i_wb_ack) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (i_wb_ack) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? '0 : i_wb_data;
        end
      end
      RESP: if (i_rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized
// transactions checked against a cycle-count/response model of the transaction.
module tb_wb_cmd_master;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [3:0]    cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata, wb_rdata;
  logic [3:0]    wb_sel;
  logic          wb_ack, wb_stall, wb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_sel(cmd_sel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata), .i_wb_err(wb_err)
  );

  // One complete transaction. Relative cycle 0 is the first stb cycle.
  // kind: 0 ack, 1 err, 2 ack+err together, 3 slave never answers.
  // The slave answers dly cycles after accepting stb (stall_n stalled cycles first).
  task automatic do_txn(input string nm, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdat, input logic [3:0] sel,
                        input int stall_n, input int dly, input int kind,
                        input logic [DW-1:0] rdat, input int hold, input bit spur);
    int            resp_cyc, exp_cyc, exp_stb, cyc_n, stb_n, rsp_at, fld_bad;
    bit            responds, normal, exp_err;
    logic [DW-1:0] exp_data;
    resp_cyc = stall_n + 1 + dly;
    responds = (kind != 3);
    normal   = responds && (resp_cyc <= TO);
    exp_err  = normal ? (kind != 0) : 1'b1;
    exp_data = (exp_err || we) ? '0 : rdat;
    exp_cyc  = normal ? resp_cyc + 1 : TO + 1;
    exp_stb  = normal ? stall_n + 1 : ((stall_n + 1 < TO + 1) ? stall_n + 1 : TO + 1);

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = wdat; cmd_sel = sel;
    wb_ack = spur; wb_err = spur; wb_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready at command: got %b want 1", nm, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
    cyc_n = 0; stb_n = 0; rsp_at = -1; fld_bad = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      wb_stall = (c < stall_n);
      wb_ack   = responds && (kind != 1) && (c == resp_cyc);
      wb_err   = responds && (kind == 1 || kind == 2) && (c == resp_cyc);
      if (spur && c == 0) begin wb_ack = 1'b1; wb_err = 1'b1; end
      wb_rdata = (c == resp_cyc) ? rdat : $urandom();
      @(negedge clk);
      if (rsp_valid === 1'b1) begin rsp_at = c; break; end
      if (wb_cyc === 1'b1) cyc_n++;
      if (wb_stb === 1'b1) begin
        stb_n++;
        if ({wb_we, wb_addr, wb_wdata, wb_sel} !== {we, addr, wdat, sel}) fld_bad++;
      end
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;

    checks++;
    if (rsp_at != exp_cyc) begin
      errors++; $display("FAIL %s rsp_valid cycle: got %0d want %0d", nm, rsp_at, exp_cyc);
    end
    if (rsp_at < 0) return;
    checks++;
    if (cyc_n != exp_cyc) begin
      errors++; $display("FAIL %s cyc cycles: got %0d want %0d", nm, cyc_n, exp_cyc);
    end
    checks++;
    if (stb_n != exp_stb) begin
      errors++; $display("FAIL %s stb cycles: got %0d want %0d", nm, stb_n, exp_stb);
    end
    checks++;
    if (fld_bad != 0) begin
      errors++; $display("FAIL %s wb fields during stb: got %0d bad cycles want 0", nm, fld_bad);
    end
    checks++;
    if ({rsp_err, rsp_data} !== {exp_err, exp_data}) begin
      errors++; $display("FAIL %s response: got err=%b data=%h want err=%b data=%h",
                         nm, rsp_err, rsp_data, exp_err, exp_data);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_data} !== {1'b1, 1'b0, exp_err, exp_data}) begin
        errors++; $display("FAIL %s hold %0d: got v=%b rdy=%b err=%b data=%h want v=1 rdy=0 err=%b data=%h",
                           nm, h, rsp_valid, cmd_ready, rsp_err, rsp_data, exp_err, exp_data);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc} !== 3'b010) begin
      errors++; $display("FAIL %s after rsp handshake: got v=%b rdy=%b cyc=%b want v=0 rdy=1 cyc=0",
                         nm, rsp_valid, cmd_ready, wb_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, wb_addr, wb_wdata, wb_sel, rsp_data} !== '0) begin
      errors++; $display("FAIL reset outputs: got cyc=%b stb=%b we=%b v=%b err=%b addr=%h wd=%h sel=%h rd=%h want all 0",
                         wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, wb_addr, wb_wdata, wb_sel, rsp_data);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    do_txn("write_basic", 1'b1, 30'h10, 32'h0000_1234, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_stall_read();
    do_txn("read_stall3", 1'b0, 30'h11, 32'h0, 4'hF, 3, 0, 0, 32'h0000_ABCD, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn("timeout_noack", 1'b0, 30'h12, 32'h0, 4'hF, 0, 0, 3, 32'h1111_2222, 0, 1'b0);
    do_txn("timeout_in_req", 1'b1, 30'h13, 32'h55, 4'h3, 12, 0, 0, 32'h0, 0, 1'b0);
    do_txn("ack_on_timeout_cycle", 1'b0, 30'h14, 32'h0, 4'hF, 2, 5, 0, 32'hCAFE_0001, 0, 1'b0);
    do_txn("ack_after_timeout", 1'b0, 30'h15, 32'h0, 4'hF, 2, 6, 0, 32'hCAFE_0002, 0, 1'b0);
  endtask

  task automatic test_ack_err();
    do_txn("ack_err_same", 1'b0, 30'h16, 32'h0, 4'hF, 0, 1, 2, 32'h7777_8888, 0, 1'b0);
    do_txn("err_write", 1'b1, 30'h17, 32'h99, 4'h1, 1, 0, 1, 32'h0, 0, 1'b0);
    do_txn("spurious_ack_req", 1'b0, 30'h18, 32'h0, 4'hF, 2, 1, 0, 32'h1357_9BDF, 0, 1'b1);
  endtask

  task automatic test_rsp_hold();
    do_txn("rsp_hold5", 1'b0, 30'h19, 32'h0, 4'hF, 1, 2, 0, 32'h2468_ACE0, 5, 1'b0);
  endtask

  task automatic test_reset_wait();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 30'h1A; cmd_sel = 4'hF; wb_stall = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb} !== 2'b10) begin
      errors++; $display("FAIL rst_wait entry: got cyc=%b stb=%b want cyc=1 stb=0", wb_cyc, wb_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL rst_wait async drop: got cyc=%b stb=%b v=%b rdy=%b want 0 0 0 1",
                         wb_cyc, wb_stb, rsp_valid, cmd_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_txn("read_after_reset", 1'b0, 30'h1B, 32'h0, 4'hF, 0, 0, 0, 32'h5A5A_0F0F, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r1, r2, r3, r4;
    int k, kind;
    for (int i = 0; i < 40; i++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); r4 = $urandom();
      k = int'($urandom_range(0, 9));
      kind = (k <= 5) ? 0 : (k <= 7) ? 1 : (k == 8) ? 2 : 3;
      do_txn($sformatf("rand%0d", i), r4[0], r1[AW-1:0], r2, r4[7:4],
             int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), kind, r3,
             int'($urandom_range(0, 2)), r4[8]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_stall_read();
    test_timeout();
    test_ack_err();
    test_rsp_hold();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
